// File: rtl/sharpx1_pkg.sv
// Sharp X1 ioctl loader: shared state encoding and lane helpers.
package sharpx1_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_FLUSH,
      S_DONE
   } ld_state_t;

   // Wide enough for the largest word (32 bits = 4 lanes).
   localparam int LANE_W = 2;
   typedef logic [LANE_W-1:0] lane_t;

   function automatic int bytes_of(int dw);
      return dw / 8;
   endfunction

   function automatic int lane_bits(int dw);
      return (dw == 32) ? 2 : (dw == 16) ? 1 : 0;
   endfunction

endpackage

// File: rtl/sharpx1_ioctl_loader_if.sv
// Sharp X1 ioctl loader: target memory write port.
interface sharpx1_ioctl_loader_if #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
);
   logic [NUM_CH-1:0] mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_we;
   logic              mem_ack;

   modport master (
      output mem_sel, mem_addr, mem_data, mem_we,
      input  mem_ack
   );

   modport slave (
      input  mem_sel, mem_addr, mem_data, mem_we,
      output mem_ack
   );
endinterface

// File: rtl/sharpx1_byte_packer.sv
// Sharp X1 ioctl loader: little-endian lane packing and byte checksum.
module sharpx1_byte_packer
   import sharpx1_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              consume,
   input  logic              wr,
   input  lane_t             lane,
   input  logic [7:0]        din,
   output logic [DATA_W-1:0] word,
   output logic              pending,
   output logic [7:0]        checksum
);
   localparam int BYTES = bytes_of(DATA_W);

   logic [DATA_W-1:0] word_q;
   logic [BYTES-1:0]  mask_q;
   logic [7:0]        sum_q;

   // Lanes never written stay zero, which gives the flush zero-fill.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_q <= '0;
         mask_q <= '0;
         sum_q  <= '0;
      end else begin
         if (clr || consume) begin
            word_q <= '0;
            mask_q <= '0;
         end else if (wr) begin
            for (int i = 0; i < BYTES; i++) begin
               if (lane == lane_t'(i)) begin
                  word_q[8*i +: 8] <= din;
                  mask_q[i]        <= 1'b1;
               end
            end
         end
         if (clr)
            sum_q <= '0;
         else if (wr)
            sum_q <= sum_q + din;
      end
   end

   assign word     = word_q;
   assign pending  = |mask_q;
   assign checksum = sum_q;
endmodule

// File: rtl/sharpx1_ioctl_loader.sv
// Sharp X1 ioctl loader: host download stream to multi-target word writes.
module sharpx1_ioctl_loader
   import sharpx1_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 8,
   parameter int INDEX_BASE = 0
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic                   ioctl_download,
   input  logic                   ioctl_wr,
   input  logic [7:0]             ioctl_index,
   input  logic [24:0]            ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   output logic                   ioctl_wait,
   sharpx1_ioctl_loader_if.master mem,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic [7:0]             checksum
);
   localparam int BYTES = bytes_of(DATA_W);
   localparam int LB    = lane_bits(DATA_W);

   ld_state_t         state;
   ld_state_t         state_n;
   logic              dl_q;
   logic [NUM_CH-1:0] sel_q;
   logic [ADDR_W-1:0] addr_q;
   logic              ovf_q;

   logic [31:0]       idx;
   logic [24:0]       waddr;
   lane_t             lane;
   logic              in_range;
   logic              start;
   logic              accept;
   logic              last;
   logic              drop;
   logic              writing;
   logic              consume;
   logic [DATA_W-1:0] word;
   logic              pending;

   assign idx      = 32'(ioctl_index);
   assign in_range = idx >= 32'(INDEX_BASE) &&
                     idx <  32'(INDEX_BASE + NUM_CH);
   assign start    = state == S_IDLE && ioctl_download &&
                     !dl_q && in_range;

   assign waddr  = ioctl_addr >> LB;
   assign lane   = ioctl_addr[1:0] & lane_t'(BYTES - 1);
   assign accept = state == S_COLLECT && ioctl_wr &&
                   (waddr >> ADDR_W) == '0;
   assign last   = accept && lane == lane_t'(BYTES - 1);

   assign writing = state == S_WRITE || state == S_FLUSH;
   assign consume = writing && mem.mem_ack;
   assign drop    = ioctl_wr &&
                    ((state == S_COLLECT && !accept) || writing);

   sharpx1_byte_packer #(
      .DATA_W (DATA_W)
   ) u_pack (
      .clk      (clk_sys),
      .rst_n    (reset_n),
      .clr      (start),
      .consume  (consume),
      .wr       (accept),
      .lane     (lane),
      .din      (ioctl_dout),
      .word     (word),
      .pending  (pending),
      .checksum (checksum)
   );

   // dl_q resets high so a download left asserted across reset is ignored.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         dl_q   <= 1'b1;
         sel_q  <= '0;
         addr_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         state <= state_n;
         dl_q  <= ioctl_download;
         if (start) begin
            sel_q <= NUM_CH'(1) << (idx - 32'(INDEX_BASE));
            ovf_q <= 1'b0;
         end else if (drop) begin
            ovf_q <= 1'b1;
         end
         if (accept)
            addr_q <= waddr[ADDR_W-1:0];
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:
            if (start)
               state_n = S_COLLECT;
         S_COLLECT:
            if (last)
               state_n = S_WRITE;
            else if (!ioctl_download)
               state_n = (pending || accept) ? S_FLUSH : S_DONE;
         S_WRITE:
            if (mem.mem_ack)
               state_n = ioctl_download ? S_COLLECT : S_DONE;
         S_FLUSH:
            if (mem.mem_ack)
               state_n = S_DONE;
         S_DONE:
            state_n = S_IDLE;
         default:
            state_n = S_IDLE;
      endcase
   end

   always_comb begin
      mem.mem_we   = 1'b0;
      mem.mem_sel  = '0;
      mem.mem_addr = '0;
      mem.mem_data = '0;
      ioctl_wait   = 1'b0;
      busy         = state != S_IDLE;
      done         = state == S_DONE;
      overflow     = ovf_q;
      if (writing) begin
         mem.mem_we   = 1'b1;
         mem.mem_sel  = sel_q;
         mem.mem_addr = addr_q;
         mem.mem_data = word;
         ioctl_wait   = 1'b1;
      end
   end
endmodule

// File: doc/sharpx1_ioctl_loader.md
SHARPX1_IOCTL_LOADER -- requirements
Module: sharpx1_ioctl_loader

Interface
REQ-001 SHALL expose parameter NUM_CH, default 4: number of memory targets.
REQ-002 SHALL expose parameter ADDR_W, default 12: word-address width per target.
REQ-003 SHALL expose parameter DATA_W, default 8: target word width; legal values are 8, 16 and 32.
REQ-004 SHALL expose parameter INDEX_BASE, default 0: the ioctl_index value mapped to channel 0.
REQ-005 SHALL have port clk_sys, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have ports ioctl_download, ioctl_wr (input, 1), ioctl_index (input, 8), ioctl_addr (input, 25) and ioctl_dout (input, 8): the host download stream.
REQ-008 SHALL have port ioctl_wait, output, 1: stalls the host while a word write is pending.
REQ-009 SHALL have ports mem_sel (output, NUM_CH, one-hot), mem_addr (output, ADDR_W), mem_data (output, DATA_W) and mem_we (output, 1): the target write port.
REQ-010 SHALL have port mem_ack, input, 1: the target accepted the current write.
REQ-011 SHALL have ports busy (output, 1), done (output, 1, single-cycle pulse), overflow (output, 1, sticky) and checksum (output, 8).

Function
REQ-012 SHALL implement states IDLE, COLLECT, WRITE, FLUSH and DONE.
REQ-013 On a rising ioctl_download edge in IDLE with INDEX_BASE <= ioctl_index < INDEX_BASE+NUM_CH, SHALL latch the channel, clear checksum, overflow and the pack register, and enter COLLECT.
REQ-014 SHALL ignore downloads whose index is out of range: state stays IDLE and no mem_we is issued.
REQ-015 In COLLECT, each ioctl_wr byte SHALL be placed little-endian in lane ioctl_addr mod (DATA_W/8) and added modulo 256 to checksum.
REQ-016 A byte in the last lane SHALL cause mem_we to assert on the next cycle, with mem_addr = ioctl_addr / (DATA_W/8) truncated to ADDR_W bits, and the FSM SHALL enter WRITE.
REQ-017 In WRITE, mem_we, mem_sel, mem_addr, mem_data and ioctl_wait SHALL hold stable until the cycle mem_ack=1; the FSM then returns to COLLECT, or goes to FLUSH/DONE if ioctl_download has fallen.
REQ-018 A byte whose word address is >= 2^ADDR_W SHALL be dropped and SHALL set overflow.
REQ-019 An ioctl_wr arriving in WRITE (host ignored ioctl_wait) SHALL set overflow and the byte SHALL be dropped.
REQ-020 A falling ioctl_download edge with a partial word pending SHALL enter FLUSH, which writes the word like WRITE, with unwritten lanes set to zero.
REQ-021 A falling edge with no partial word pending SHALL go directly to DONE.
REQ-022 DONE SHALL last one cycle, pulse done=1 and return to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 mem_sel SHALL be nonzero only while mem_we=1.
REQ-025 ioctl_wr coincident with the falling download edge SHALL be accepted before the flush.

Reset
REQ-026 reset_n=0 SHALL force IDLE and drive ioctl_wait, mem_we, mem_sel, mem_addr, mem_data, busy, done, overflow and checksum to 0 on the next edge, including mid-WRITE.
REQ-027 After reset, a download still high SHALL be ignored until it falls and rises again.

Structure
REQ-028 The state enumeration, the BYTES = DATA_W/8 constant and the lane-index width SHALL reside in a shared package sharpx1_pkg.
REQ-029 Byte lane packing, zero-fill and checksum SHALL be one sub-module, sharpx1_byte_packer; the FSM and handshake SHALL stay in the top.

Verification
REQ-030 DATA_W=8, index 0, bytes 0x11,0x22 at addr 0,1, mem_ack tied 1 -> two writes: addr 0 = 0x11, addr 1 = 0x22, mem_sel=0001, checksum=0x33, one done pulse.
REQ-031 DATA_W=16, three bytes 0xAA,0xBB,0xCC -> write addr 0 = 0xBBAA, then flush addr 1 = 0x00CC, done.
REQ-032 DATA_W=32, mem_ack delayed 5 cycles -> ioctl_wait high for exactly those cycles, outputs stable, write completes on the ack cycle.
REQ-033 ADDR_W=4, DATA_W=8, byte at addr 16 -> no mem_we, overflow=1.
REQ-034 Index 7 with NUM_CH=4 -> no writes, busy stays 0; then reset_n=0 asserted mid-WRITE on a valid download -> all outputs 0 on the next cycle.
